// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {SCAN, CONFIRM, PRESSED} kp_state_t;

  typedef struct packed {
    logic [1:0] idx;
    logic       valid;
    logic       multi;
  } col_enc_t;

  // Active-low column encode; the lowest-index low column wins.
  function automatic col_enc_t col_encode(input logic [NUM_COLS-1:0] c);
    col_enc_t e;
    int       n;
    e = '0;
    n = 0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!c[i]) begin
        e.idx   = 2'(i);
        e.valid = 1'b1;
        n++;
      end
    end
    e.multi = (n > 1);
    return e;
  endfunction
endpackage

// File: rtl/col_sync.sv
// 2-FF synchroniser for the asynchronous active-low column returns.
import keypad_pkg::*;

module col_sync (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] d,
  output logic [NUM_COLS-1:0] q
);
  logic [NUM_COLS-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with debounce and one-hot key output.
// Define KEYPAD_GHOST_REJECT_EN to treat multi-column samples as "no key".
import keypad_pkg::*;

module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] onehot,
  output logic        key_strobe
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
`ifdef KEYPAD_GHOST_REJECT_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic [3:0]    col_s;
  logic [DW-1:0] div;
  logic          tick;
  kp_state_t     state, state_nxt;
  logic [1:0]    row_idx, row_idx_nxt;
  logic [3:0]    code, code_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [15:0]   onehot_nxt;
  logic          strobe_nxt;
  col_enc_t      enc;
  logic          key_ok, same_col, cap_low;

  col_sync u_sync (.clk(clk), .rst(rst), .d(col), .q(col_s));

  assign tick = (div == DW'(SCAN_DIV - 1));
  assign row  = ~(4'b0001 << row_idx);

  always_ff @(posedge clk) begin
    if (rst) div <= '0;
    else     div <= tick ? '0 : div + 1'b1;
  end

  // Ghost samples look like "no key" in every state when rejection is on.
  assign enc      = col_encode(col_s);
  assign key_ok   = enc.valid & ~(GHOST & enc.multi);
  assign same_col = key_ok & (enc.idx == code[1:0]);
  assign cap_low  = ~col_s[code[1:0]] & ~(GHOST & enc.multi);
  assign cnt_inc  = cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    row_idx_nxt = row_idx;
    code_nxt    = code;
    cnt_nxt     = cnt;
    onehot_nxt  = onehot;
    strobe_nxt  = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (key_ok) begin
            code_nxt = {row_idx, enc.idx};
            if (DEBOUNCE_CNT == 1) begin
              state_nxt  = PRESSED;
              cnt_nxt    = '0;
              onehot_nxt = 16'h0001 << {row_idx, enc.idx};
              strobe_nxt = 1'b1;
            end else begin
              state_nxt = CONFIRM;
              cnt_nxt   = CW'(1);
            end
          end else begin
            row_idx_nxt = row_idx + 1'b1;
          end
        end
        CONFIRM: begin
          if (same_col) begin
            if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
              state_nxt  = PRESSED;
              cnt_nxt    = '0;
              onehot_nxt = 16'h0001 << code;
              strobe_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt   = SCAN;
            cnt_nxt     = '0;
            row_idx_nxt = row_idx + 1'b1;
          end
        end
        PRESSED: begin
          if (cap_low) begin
            cnt_nxt = '0;
          end else if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
            state_nxt   = SCAN;
            cnt_nxt     = '0;
            onehot_nxt  = '0;
            row_idx_nxt = row_idx + 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN;
      row_idx    <= '0;
      code       <= '0;
      cnt        <= '0;
      onehot     <= '0;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_nxt;
      row_idx    <= row_idx_nxt;
      code       <= code_nxt;
      cnt        <= cnt_nxt;
      onehot     <= onehot_nxt;
      key_strobe <= strobe_nxt;
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad matrix model drives col from row,
// expected onehot/strobe events are queued and checked by a separate monitor.
module tb_keypad_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col, row;
  logic [15:0] onehot;
  logic        key_strobe;
  logic [15:0] pressed = '0;

  typedef struct { logic [15:0] oh; logic stb; } exp_t;
  exp_t        expq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] prev_oh = '0;

  always #5 clk = ~clk;

  // Key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row),
    .onehot(onehot), .key_strobe(key_strobe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic wait_oh(input logic [15:0] v, input int budget, input string name);
    int n = 0;
    while (onehot !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(onehot), 32'(v));
  endtask

  task automatic wait_row0_start();
    int n = 0;
    while (row == 4'b1110 && n < 40) begin @(negedge clk); n++; end
    while (row != 4'b1110 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("row0_timeout", 32'(row), 32'(4'b1110));
  endtask

  // Monitor: every onehot change must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (onehot !== prev_oh) begin
      if (expq.size() == 0) begin
        chk("unexpected_onehot", 32'(onehot), 32'(prev_oh));
      end else begin
        e = expq.pop_front();
        chk("onehot", 32'(onehot), 32'(e.oh));
        chk("strobe", 32'(key_strobe), 32'(e.stb));
      end
      prev_oh = onehot;
    end else if (key_strobe !== 1'b0) begin
      chk("stray_strobe", 32'(key_strobe), 32'(0));
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_row", 32'(row), 32'(4'b1110));
    chk("reset_onehot", 32'(onehot), 32'(0));
    chk("reset_strobe", 32'(key_strobe), 32'(0));
    rst = 1'b0;

    // clean press row2/col1, row frozen while held
    expq.push_back('{16'h0200, 1'b1});
    pressed = 16'h0200;
    wait_oh(16'h0200, 60, "press_latency");
    for (int i = 0; i < 3; i++) begin
      repeat (5) @(negedge clk);
      chk("row_frozen", 32'(row), 32'(4'b1011));
    end

    // clean release, scanning resumes at row3
    expq.push_back('{16'h0000, 1'b0});
    pressed = '0;
    wait_oh(16'h0000, 18, "release_latency");
    chk("resume_row3", 32'(row), 32'(4'b0111));

    // short bounce row0/col3: two matching ticks, then gone
    wait_row0_start();
    pressed = 16'h0008;
    repeat (8) @(negedge clk);
    pressed = '0;
    repeat (4) @(negedge clk);
    chk("bounce_row_adv", 32'(row), 32'(4'b1101));
    chk("bounce_onehot", 32'(onehot), 32'(0));

    // two keys in row1: col0 and col2
`ifndef KEYPAD_GHOST_REJECT_EN
    expq.push_back('{16'h0010, 1'b1});
`endif
    pressed = 16'h0050;
    repeat (50) @(negedge clk);
`ifdef KEYPAD_GHOST_REJECT_EN
    chk("two_key", 32'(onehot), 32'(16'h0000));
`else
    chk("two_key", 32'(onehot), 32'(16'h0010));
    expq.push_back('{16'h0000, 1'b0});
`endif
    pressed = '0;
    repeat (25) @(negedge clk);
    chk("two_key_clear", 32'(onehot), 32'(0));

    // reset mid-press, key still held, full re-confirmation
    expq.push_back('{16'h0008, 1'b1});
    pressed = 16'h0008;
    wait_oh(16'h0008, 60, "rst_pre_press");
    expq.push_back('{16'h0000, 1'b0});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_row", 32'(row), 32'(4'b1110));
    chk("rst_mid_onehot", 32'(onehot), 32'(0));
    chk("rst_mid_strobe", 32'(key_strobe), 32'(0));
    expq.push_back('{16'h0008, 1'b1});
    n = 0;
    while (onehot == 16'h0000 && n < 40) begin @(negedge clk); n++; end
    chk("rst_relatency", 32'(n), 32'(12));
    expq.push_back('{16'h0000, 1'b0});
    pressed = '0;
    wait_oh(16'h0000, 20, "rst_release");

    // row isolation: row3 held, row0 pressed later
    expq.push_back('{16'h4000, 1'b1});
    pressed = 16'h4000;
    wait_oh(16'h4000, 60, "iso_press");
    pressed = 16'h4001;
    repeat (30) @(negedge clk);
    chk("iso_hold", 32'(onehot), 32'(16'h4000));
    chk("iso_row", 32'(row), 32'(4'b0111));
    expq.push_back('{16'h0000, 1'b0});
    expq.push_back('{16'h0001, 1'b1});
    pressed = 16'h0001;
    wait_oh(16'h0001, 45, "iso_next_key");
    expq.push_back('{16'h0000, 1'b0});
    pressed = '0;
    wait_oh(16'h0000, 20, "iso_release");

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
